// File: rtl/kart_motion.sv
// -----------------------------------------------------------------------------
// kart_motion
//   Per-kart world position generator. Once per frame tick it steers, updates
//   speed, moves the kart along its heading, clamps to the track and publishes
//   the new state with a one-cycle valid strobe. One instance per kart.
//
// Ports
//   clk_in         system clock
//   rst_in         synchronous reset, active low
//   frame_tick_in  one-cycle pulse at start of vertical blanking
//   accel_in       accelerate request (level)
//   brake_in       brake request (level)
//   left_in        steer left (level)
//   right_in       steer right (level)
//   player_x       published x position (11-bit world units)
//   player_y       published y position
//   heading_out    published heading, 0=+x 4=+y 8=-x 12=-y
//   speed_out      published speed
//   pos_valid_out  one-cycle strobe when new values are published
//   overrun_out    sticky: a frame tick had to be dropped
// -----------------------------------------------------------------------------
module kart_motion #(
    parameter logic [10:0] START_X       = 11'd1960,
    parameter logic [10:0] START_Y       = 11'd1960,
    parameter logic [3:0]  START_HEADING = 4'd0,
    parameter logic [10:0] TRACK_MAX     = 11'd2047,
    parameter logic [3:0]  MAX_SPEED     = 4'd15
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        frame_tick_in,
    input  logic        accel_in,
    input  logic        brake_in,
    input  logic        left_in,
    input  logic        right_in,
    output logic [10:0] player_x,
    output logic [10:0] player_y,
    output logic [3:0]  heading_out,
    output logic [3:0]  speed_out,
    output logic        pos_valid_out,
    output logic        overrun_out
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STEER   = 3'd1,
        SPEED   = 3'd2,
        MOVE    = 3'd3,
        CLAMP   = 3'd4,
        PUBLISH = 3'd5
    } state_t;

    state_t             state_r;
    logic               pending_r;
    logic               accel_r;
    logic               brake_r;
    logic               left_r;
    logic               right_r;
    logic [3:0]         heading_r;
    logic [3:0]         speed_r;
    logic signed [12:0] pos_x_r;
    logic signed [12:0] pos_y_r;
    logic [10:0]        player_x_r;
    logic [10:0]        player_y_r;
    logic [3:0]         heading_out_r;
    logic [3:0]         speed_out_r;
    logic               pos_valid_r;
    logic               overrun_r;
    logic signed [12:0] dx_s;
    logic signed [12:0] dy_s;

    // Direction cosine table scaled by 8 (index = heading).
    function automatic logic signed [4:0] dir_coef(input logic [3:0] h);
        logic signed [4:0] c;
        case (h)
            4'd0:    c =  5'sd8;
            4'd1:    c =  5'sd7;
            4'd2:    c =  5'sd6;
            4'd3:    c =  5'sd3;
            4'd4:    c =  5'sd0;
            4'd5:    c = -5'sd3;
            4'd6:    c = -5'sd6;
            4'd7:    c = -5'sd7;
            4'd8:    c = -5'sd8;
            4'd9:    c = -5'sd7;
            4'd10:   c = -5'sd6;
            4'd11:   c = -5'sd3;
            4'd12:   c =  5'sd0;
            4'd13:   c =  5'sd3;
            4'd14:   c =  5'sd6;
            4'd15:   c =  5'sd7;
            default: c =  5'sd0;
        endcase
        return c;
    endfunction

    // coef*speed/8 rounded toward minus infinity (arithmetic shift).
    function automatic logic signed [12:0] step_delta(input logic signed [4:0] coef,
                                                      input logic [3:0] spd);
        logic signed [12:0] prod;
        prod = $signed({{8{coef[4]}}, coef}) * $signed({9'd0, spd});
        return prod >>> 3'd3;
    endfunction

    // Limit a signed working coordinate to 0..TRACK_MAX.
    function automatic logic signed [12:0] clamp_coord(input logic signed [12:0] v);
        logic signed [12:0] r;
        if (v < 13'sd0) begin
            r = 13'sd0;
        end else if (v > $signed({2'b00, TRACK_MAX})) begin
            r = $signed({2'b00, TRACK_MAX});
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Per-frame displacement from the already-updated heading and speed.
    always_comb begin
        dx_s = step_delta(dir_coef(heading_r), speed_r);
        dy_s = step_delta(dir_coef(heading_r - 4'd4), speed_r);
    end

    // Update sequencer, tick bookkeeping and registered outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_r       <= IDLE;
            pending_r     <= 1'b0;
            accel_r       <= 1'b0;
            brake_r       <= 1'b0;
            left_r        <= 1'b0;
            right_r       <= 1'b0;
            heading_r     <= START_HEADING;
            speed_r       <= 4'd0;
            pos_x_r       <= $signed({2'b00, START_X});
            pos_y_r       <= $signed({2'b00, START_Y});
            player_x_r    <= START_X;
            player_y_r    <= START_Y;
            heading_out_r <= START_HEADING;
            speed_out_r   <= 4'd0;
            pos_valid_r   <= 1'b0;
            overrun_r     <= 1'b0;
        end else begin
            pos_valid_r <= 1'b0;

            // A tick during an update is remembered once; a second one is lost.
            if (frame_tick_in && (state_r != IDLE)) begin
                if (pending_r) begin
                    overrun_r <= 1'b1;
                end else begin
                    pending_r <= 1'b1;
                end
            end

            case (state_r)
                IDLE: begin
                    if (frame_tick_in || pending_r) begin
                        // A tick coinciding with pending is absorbed here.
                        pending_r <= 1'b0;
                        accel_r   <= accel_in;
                        brake_r   <= brake_in;
                        left_r    <= left_in;
                        right_r   <= right_in;
                        state_r   <= STEER;
                    end
                end
                STEER: begin
                    // Steering needs the kart to be rolling already.
                    if (speed_r != 4'd0) begin
                        if (left_r && !right_r) begin
                            heading_r <= heading_r - 4'd1;
                        end else if (right_r && !left_r) begin
                            heading_r <= heading_r + 4'd1;
                        end
                    end
                    state_r <= SPEED;
                end
                SPEED: begin
                    if (brake_r) begin
                        speed_r <= (speed_r >= 4'd2) ? (speed_r - 4'd2) : 4'd0;
                    end else if (accel_r) begin
                        speed_r <= (speed_r >= MAX_SPEED) ? MAX_SPEED : (speed_r + 4'd1);
                    end else begin
                        speed_r <= (speed_r != 4'd0) ? (speed_r - 4'd1) : 4'd0;
                    end
                    state_r <= MOVE;
                end
                MOVE: begin
                    pos_x_r <= pos_x_r + dx_s;
                    pos_y_r <= pos_y_r + dy_s;
                    state_r <= CLAMP;
                end
                CLAMP: begin
                    pos_x_r <= clamp_coord(pos_x_r);
                    pos_y_r <= clamp_coord(pos_y_r);
                    state_r <= PUBLISH;
                end
                PUBLISH: begin
                    player_x_r    <= pos_x_r[10:0];
                    player_y_r    <= pos_y_r[10:0];
                    heading_out_r <= heading_r;
                    speed_out_r   <= speed_r;
                    pos_valid_r   <= 1'b1;
                    state_r       <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign player_x      = player_x_r;
    assign player_y      = player_y_r;
    assign heading_out   = heading_out_r;
    assign speed_out     = speed_out_r;
    assign pos_valid_out = pos_valid_r;
    assign overrun_out   = overrun_r;

endmodule

// File: tb/tb_kart_motion.sv
// -----------------------------------------------------------------------------
// tb_kart_motion
//   Three kart_motion instances share one stimulus stream: default start,
//   start near the east edge, and start near the west edge heading west.
//   A behavioural model pushes expected published values (and the cycle of
//   the strobe) into a scoreboard when a tick is driven; a monitor pops and
//   compares on every strobe.
// -----------------------------------------------------------------------------
module tb_kart_motion;

    localparam int N = 3;

    typedef struct packed {
        logic [31:0]           cyc;
        logic [N-1:0][10:0]    x;
        logic [N-1:0][10:0]    y;
        logic [N-1:0][3:0]     h;
        logic [N-1:0][3:0]     s;
    } sb_t;

    logic clk = 1'b0;
    logic rst_in;
    logic frame_tick;
    logic accel;
    logic brake;
    logic left;
    logic right;

    logic [10:0] px [N];
    logic [10:0] py [N];
    logic [3:0]  ph [N];
    logic [3:0]  ps [N];
    logic        pv [N];
    logic        po [N];

    int st_x [N] = '{1960, 2044, 4};
    int st_y [N] = '{1960, 1960, 1960};
    int st_h [N] = '{0, 0, 8};
    int ctab [16] = '{8, 7, 6, 3, 0, -3, -6, -7, -8, -7, -6, -3, 0, 3, 6, 7};

    int mx [N];
    int my [N];
    int mh [N];
    int ms [N];

    sb_t sbq [$];
    sb_t mon_e;

    int cyc        = 0;
    int n_checks   = 0;
    int n_errors   = 0;
    int strobe_cnt = 0;
    int pushed_cnt = 0;
    int t0;

    logic [3:0] steer_seq [22] = '{
        4'b0100, 4'b0100, 4'b0010, 4'b1100, 4'b1000, 4'b1100,
        4'b1000, 4'b0110, 4'b1000, 4'b0110, 4'b1000, 4'b0110,
        4'b1000, 4'b0110, 4'b1000, 4'b0110, 4'b1000, 4'b0110,
        4'b1000, 4'b1011, 4'b0000, 4'b0000
    };

    kart_motion dut_a (
        .clk_in(clk), .rst_in(rst_in), .frame_tick_in(frame_tick),
        .accel_in(accel), .brake_in(brake), .left_in(left), .right_in(right),
        .player_x(px[0]), .player_y(py[0]), .heading_out(ph[0]), .speed_out(ps[0]),
        .pos_valid_out(pv[0]), .overrun_out(po[0])
    );

    kart_motion #(.START_X(11'd2044)) dut_b (
        .clk_in(clk), .rst_in(rst_in), .frame_tick_in(frame_tick),
        .accel_in(accel), .brake_in(brake), .left_in(left), .right_in(right),
        .player_x(px[1]), .player_y(py[1]), .heading_out(ph[1]), .speed_out(ps[1]),
        .pos_valid_out(pv[1]), .overrun_out(po[1])
    );

    kart_motion #(.START_X(11'd4), .START_HEADING(4'd8)) dut_c (
        .clk_in(clk), .rst_in(rst_in), .frame_tick_in(frame_tick),
        .accel_in(accel), .brake_in(brake), .left_in(left), .right_in(right),
        .player_x(px[2]), .player_y(py[2]), .heading_out(ph[2]), .speed_out(ps[2]),
        .pos_valid_out(pv[2]), .overrun_out(po[2])
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Cycle counter used to timestamp strobes.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i] = st_x[i];
            my[i] = st_y[i];
            mh[i] = st_h[i];
            ms[i] = 0;
        end
    endtask

    // Apply one update to every kart model and queue the expected result.
    task automatic push_model(input logic [3:0] ctl, input int exp_cyc);
        sb_t  e;
        logic a, b, l, r;
        int   h, s, nx, ny;
        {a, b, l, r} = ctl;
        e     = '0;
        e.cyc = 32'(exp_cyc);
        for (int i = 0; i < N; i++) begin
            h = mh[i];
            s = ms[i];
            if (s != 0) begin
                if (l && !r)      h = (h + 15) % 16;
                else if (r && !l) h = (h + 1) % 16;
            end
            if (b)      s = (s >= 2) ? s - 2 : 0;
            else if (a) s = (s >= 15) ? 15 : s + 1;
            else        s = (s > 0) ? s - 1 : 0;
            nx = mx[i] + ((ctab[h] * s) >>> 3);
            ny = my[i] + ((ctab[(h + 12) % 16] * s) >>> 3);
            if (nx < 0) nx = 0; else if (nx > 2047) nx = 2047;
            if (ny < 0) ny = 0; else if (ny > 2047) ny = 2047;
            mx[i] = nx; my[i] = ny; mh[i] = h; ms[i] = s;
            e.x[i] = 11'(nx);
            e.y[i] = 11'(ny);
            e.h[i] = 4'(h);
            e.s[i] = 4'(s);
        end
        sbq.push_back(e);
        pushed_cnt++;
    endtask

    // One isolated tick; controls are scrambled during the update.
    task automatic tick_update(input logic [3:0] ctl);
        @(negedge clk);
        {accel, brake, left, right} = ctl;
        frame_tick = 1'b1;
        push_model(ctl, cyc + 6);
        @(negedge clk);
        frame_tick = 1'b0;
        {accel, brake, left, right} = ~ctl;
        repeat (8) @(negedge clk);
    endtask

    task automatic check_reset_state();
        for (int i = 0; i < N; i++) begin
            check_eq($sformatf("rst_x%0d", i), 32'(px[i]), 32'(st_x[i]));
            check_eq($sformatf("rst_y%0d", i), 32'(py[i]), 32'(st_y[i]));
            check_eq($sformatf("rst_h%0d", i), 32'(ph[i]), 32'(st_h[i]));
            check_eq($sformatf("rst_s%0d", i), 32'(ps[i]), 32'd0);
            check_eq($sformatf("rst_valid%0d", i), 32'(pv[i]), 32'd0);
            check_eq($sformatf("rst_ovr%0d", i), 32'(po[i]), 32'd0);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (pv[0] || pv[1] || pv[2]) begin
            strobe_cnt++;
            if (sbq.size() == 0) begin
                check_eq("spurious_strobe", 32'(pv[0] | pv[1] | pv[2]), 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                check_eq("strobe_cyc", 32'(cyc), mon_e.cyc);
                for (int i = 0; i < N; i++) begin
                    check_eq($sformatf("valid%0d", i), 32'(pv[i]), 32'd1);
                    check_eq($sformatf("x%0d", i), 32'(px[i]), 32'(mon_e.x[i]));
                    check_eq($sformatf("y%0d", i), 32'(py[i]), 32'(mon_e.y[i]));
                    check_eq($sformatf("h%0d", i), 32'(ph[i]), 32'(mon_e.h[i]));
                    check_eq($sformatf("s%0d", i), 32'(ps[i]), 32'(mon_e.s[i]));
                end
            end
        end
    end

    // Main stimulus sequence.
    initial begin
        rst_in = 1'b0;
        frame_tick = 1'b0;
        {accel, brake, left, right} = 4'b0000;
        model_reset();
        repeat (2) @(negedge clk);
        rst_in = 1'b1;
        @(negedge clk);
        check_reset_state();

        // Straight-line acceleration; east edge clamps, west edge clamps.
        repeat (3) tick_update(4'b1000);
        check_eq("accel_x_a", 32'(px[0]), 32'd1966);
        check_eq("accel_y_a", 32'(py[0]), 32'd1960);
        check_eq("accel_s_a", 32'(ps[0]), 32'd3);
        check_eq("clamp_hi_x_b", 32'(px[1]), 32'd2047);
        check_eq("clamp_lo_x_c", 32'(px[2]), 32'd0);

        // Braking, steering at rest, brake+accel, walk heading to 10.
        for (int k = 0; k < 22; k++) begin
            tick_update(steer_seq[k]);
            if (k == 2)  check_eq("no_steer_at_rest", 32'(ph[0]), 32'd0);
            if (k == 5)  check_eq("brake_accel_s", 32'(ps[0]), 32'd0);
            if (k == 18) check_eq("heading10", 32'(ph[0]), 32'd10);
        end

        // Second tick during an update becomes pending; no overrun.
        @(negedge clk);
        {accel, brake, left, right} = 4'b1000;
        frame_tick = 1'b1;
        t0 = cyc;
        push_model(4'b1000, t0 + 6);
        push_model(4'b1000, t0 + 12);
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        repeat (12) @(negedge clk);
        for (int i = 0; i < N; i++) check_eq($sformatf("no_ovr%0d", i), 32'(po[i]), 32'd0);

        // Third tick while pending is dropped and flagged.
        @(negedge clk);
        frame_tick = 1'b1;
        t0 = cyc;
        push_model(4'b1000, t0 + 6);
        push_model(4'b1000, t0 + 12);
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        repeat (12) @(negedge clk);
        for (int i = 0; i < N; i++) check_eq($sformatf("ovr%0d", i), 32'(po[i]), 32'd1);
        check_eq("strobes_after_collide", 32'(strobe_cnt), 32'(pushed_cnt));

        // Reset while the update is in MOVE: no strobe, reset values.
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk);
        @(negedge clk); rst_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_in = 1'b1;
        model_reset();
        check_reset_state();
        repeat (8) @(negedge clk);
        tick_update(4'b1000);
        check_eq("post_rst_x_a", 32'(px[0]), 32'd1961);

        repeat (4) @(negedge clk);
        check_eq("missed_strobes", 32'(sbq.size()), 32'd0);
        check_eq("strobe_total", 32'(strobe_cnt), 32'(pushed_cnt));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
